// File: rtl/tdc_echo_pre.sv
// Multi-echo TDC pre-processing: collects validated rise/fall hits per shot and
// streams the selected echoes (first/last/widest/all) as rise time + pulse width.
module tdc_echo_pre #(
   parameter int             DW       = 16,
   parameter int             MAX_ECHO = 4,
   parameter int             IDX_W    = 2,
   parameter logic [DW-1:0]  MIN_PW   = '0,
   parameter logic [DW-1:0]  MAX_PW   = '1
) (
   input  logic             i_clk_50m,
   input  logic             i_rst,
   input  logic             i_shot_start,
   input  logic             i_shot_end,
   input  logic [1:0]       i_mode,
   input  logic             i_tdc_new_sig,
   input  logic [DW-1:0]    i_rise_data,
   input  logic [DW-1:0]    i_fall_data,
   output logic [DW-1:0]    o_rise_data,
   output logic [DW-1:0]    o_pulse_data,
   output logic [IDX_W-1:0] o_echo_idx,
   output logic [IDX_W:0]   o_echo_cnt,
   output logic             o_dist_cal_sig,
   output logic             o_echo_last,
   output logic             o_overflow
);

   typedef enum logic [1:0] {IDLE, COLLECT, SELECT, EMIT} state_t;

   // One wider bit lets a single unsigned compare cover both pulse-width bounds.
   localparam logic [DW:0]    SPAN    = {1'b0, MAX_PW} - {1'b0, MIN_PW};
   localparam logic [IDX_W:0] CNT_MAX = (IDX_W+1)'(MAX_ECHO);

   state_t           state;
   logic             tdc_q, tdc_q2;
   logic [1:0]       mode_q;
   logic [IDX_W:0]   cnt;
   logic             ovf;
   logic [DW-1:0]    best_pw;
   logic [IDX_W-1:0] best_idx, ptr, stop_q;
   logic [DW-1:0]    hit_rise [MAX_ECHO];
   logic [DW-1:0]    hit_pw   [MAX_ECHO];

   logic             det, accept, full, store, ovf_n;
   logic [DW-1:0]    pw;
   logic [DW:0]      off;
   logic [IDX_W-1:0] cnt_m1, sel_start, sel_stop, rd_idx, rd_stop;

   always_comb begin
      det       = tdc_q & ~tdc_q2;
      pw        = i_fall_data - i_rise_data;
      off       = {1'b0, pw} - {1'b0, MIN_PW};
      accept    = det && (i_fall_data >= i_rise_data) && (off <= SPAN);
      full      = (cnt == CNT_MAX);
      store     = (state == COLLECT) && !i_shot_start && accept && !full;
      cnt_m1    = IDX_W'(cnt - 1'b1);
      sel_start = '0;
      sel_stop  = '0;
      case (mode_q)
         2'd0: begin sel_start = '0;       sel_stop = '0;       end
         2'd1: begin sel_start = cnt_m1;   sel_stop = cnt_m1;   end
         2'd2: begin sel_start = best_idx; sel_stop = best_idx; end
         default: begin sel_start = '0;    sel_stop = cnt_m1;   end
      endcase
      rd_idx  = (state == SELECT) ? sel_start : ptr;
      rd_stop = (state == SELECT) ? sel_stop  : stop_q;
      // Hits arriving after the window closed still flag the pending outputs.
      ovf_n   = ovf | det;
   end

   always_ff @(posedge i_clk_50m) begin
      if (store) begin
         hit_rise[cnt[IDX_W-1:0]] <= i_rise_data;
         hit_pw[cnt[IDX_W-1:0]]   <= pw;
      end
   end

   always_ff @(posedge i_clk_50m) begin
      if (i_rst) begin
         tdc_q  <= 1'b0;
         tdc_q2 <= 1'b0;
      end else begin
         tdc_q  <= i_tdc_new_sig;
         tdc_q2 <= tdc_q;
      end
   end

   always_ff @(posedge i_clk_50m) begin
      if (i_rst) begin
         state          <= IDLE;
         mode_q         <= '0;
         cnt            <= '0;
         ovf            <= 1'b0;
         best_pw        <= '0;
         best_idx       <= '0;
         ptr            <= '0;
         stop_q         <= '0;
         o_rise_data    <= '0;
         o_pulse_data   <= '0;
         o_echo_idx     <= '0;
         o_echo_cnt     <= '0;
         o_dist_cal_sig <= 1'b0;
         o_echo_last    <= 1'b0;
         o_overflow     <= 1'b0;
      end else begin
         o_dist_cal_sig <= 1'b0;
         o_echo_last    <= 1'b0;
         o_overflow     <= 1'b0;
         case (state)
            IDLE: begin
               if (i_shot_start) begin
                  mode_q   <= i_mode;
                  cnt      <= '0;
                  ovf      <= 1'b0;
                  best_pw  <= '0;
                  best_idx <= '0;
                  state    <= COLLECT;
               end
            end
            COLLECT: begin
               if (i_shot_start) begin
                  mode_q   <= i_mode;
                  cnt      <= '0;
                  ovf      <= 1'b0;
                  best_pw  <= '0;
                  best_idx <= '0;
               end else begin
                  if (accept) begin
                     if (full) begin
                        ovf <= 1'b1;
                     end else begin
                        cnt <= cnt + 1'b1;
                        // Strict compare: ties keep the earliest echo.
                        if (cnt == '0 || pw > best_pw) begin
                           best_pw  <= pw;
                           best_idx <= cnt[IDX_W-1:0];
                        end
                     end
                  end
                  if (i_shot_end) state <= SELECT;
               end
            end
            SELECT, EMIT: begin
               ovf            <= ovf_n;
               o_dist_cal_sig <= 1'b1;
               o_overflow     <= ovf_n;
               o_echo_cnt     <= cnt;
               if (state == SELECT && cnt == '0) begin
                  o_rise_data  <= '0;
                  o_pulse_data <= '0;
                  o_echo_idx   <= '0;
                  o_echo_last  <= 1'b1;
                  state        <= IDLE;
               end else begin
                  o_rise_data  <= hit_rise[rd_idx];
                  o_pulse_data <= hit_pw[rd_idx];
                  o_echo_idx   <= rd_idx;
                  o_echo_last  <= (rd_idx == rd_stop);
                  ptr          <= IDX_W'(rd_idx + 1'b1);
                  stop_q       <= rd_stop;
                  state        <= (rd_idx == rd_stop) ? IDLE : EMIT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tdc_echo_pre.sv
// Bench for tdc_echo_pre: vector table, hand-built corner sequences and random
// shots checked against a list-based reference of the echo selection rules.
module tb_tdc_echo_pre;
   localparam int DW = 16, ME = 4, IW = 2;
   localparam int MINP = 8, MAXP = 200;
   typedef logic [DW-1:0] w_t;
   typedef logic [0:7][DW-1:0] h8_t;

   logic clk = 1'b0, rst = 1'b1, shot_start = 1'b0, shot_end = 1'b0, tdc_sig = 1'b0;
   logic [1:0] mode_i = 2'd0;
   w_t rise_i = '0, fall_i = '0;
   w_t o_rise, o_pulse;
   logic [IW-1:0] o_idx;
   logic [IW:0] o_cnt;
   logic o_sig, o_last, o_ovf;

   tdc_echo_pre #(.DW(DW), .MAX_ECHO(ME), .IDX_W(IW), .MIN_PW(16'd8), .MAX_PW(16'd200)) dut (
      .i_clk_50m(clk), .i_rst(rst), .i_shot_start(shot_start), .i_shot_end(shot_end),
      .i_mode(mode_i), .i_tdc_new_sig(tdc_sig), .i_rise_data(rise_i), .i_fall_data(fall_i),
      .o_rise_data(o_rise), .o_pulse_data(o_pulse), .o_echo_idx(o_idx), .o_echo_cnt(o_cnt),
      .o_dist_cal_sig(o_sig), .o_echo_last(o_last), .o_overflow(o_ovf));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, fails = 0;

   typedef struct {int cyc; int rise; int pulse; int idx; int cnt; bit last; bit ovf;} ev_t;
   ev_t obs[$];

   always @(negedge clk) begin
      if (o_sig) begin
         obs.push_back('{cyc, int'(o_rise), int'(o_pulse), int'(o_idx), int'(o_cnt), o_last, o_ovf});
      end else begin
         checks++;
         if (o_last || o_ovf) begin
            fails++;
            $display("FAIL idle_flags cyc=%0d last=%0b ovf=%0b required 0", cyc, o_last, o_ovf);
         end
      end
   end

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   function automatic h8_t h8(input int v0 = 0, v1 = 0, v2 = 0, v3 = 0, v4 = 0, v5 = 0, v6 = 0, v7 = 0);
      h8_t h;
      h[0] = w_t'(v0); h[1] = w_t'(v1); h[2] = w_t'(v2); h[3] = w_t'(v3);
      h[4] = w_t'(v4); h[5] = w_t'(v5); h[6] = w_t'(v6); h[7] = w_t'(v7);
      return h;
   endfunction

   task automatic hit(input w_t r, input w_t f);
      rise_i = r; fall_i = f; tdc_sig = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      tdc_sig = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic start_shot(input logic [1:0] m);
      shot_start = 1'b1; mode_i = m;
      @(posedge clk); #1;
      shot_start = 1'b0; mode_i = ~m;
   endtask

   task automatic end_shot(output int t_end);
      shot_end = 1'b1; t_end = cyc;
      @(posedge clk); #1;
      shot_end = 1'b0;
   endtask

   task automatic run_shot(input logic [1:0] m, input int n, input h8_t r, input h8_t f,
                           input bit ewh, output int t_end);
      obs.delete();
      t_end = 0;
      start_shot(m);
      for (int i = 0; i < n; i++) begin
         if (ewh && i == n - 1) begin
            // Detect cycle coincides with shot_end.
            rise_i = r[i]; fall_i = f[i]; tdc_sig = 1'b1;
            @(posedge clk); #1;
            shot_end = 1'b1; t_end = cyc;
            @(posedge clk); #1;
            shot_end = 1'b0; tdc_sig = 1'b0;
            @(posedge clk); #1;
         end else begin
            hit(r[i], f[i]);
         end
      end
      if (!(ewh && n > 0)) end_shot(t_end);
      repeat (ME + 4) @(posedge clk);
      #1;
   endtask

   // Reference: filter hits, keep the first ME accepted, pick per mode, list echoes.
   task automatic model_check(input string nm, input logic [1:0] m, input int n,
                              input h8_t r, input h8_t f, input int t_end);
      int ar[$], ap[$], sel[$];
      bit ov = 1'b0;
      int best, en, lim;
      for (int i = 0; i < n; i++) begin
         int ri = int'(r[i]), fi = int'(f[i]), pw;
         pw = fi - ri;
         if (fi >= ri && pw >= MINP && pw <= MAXP) begin
            if (ar.size() < ME) begin ar.push_back(ri); ap.push_back(pw); end
            else ov = 1'b1;
         end
      end
      if (ar.size() > 0) begin
         case (m)
            2'd0: sel.push_back(0);
            2'd1: sel.push_back(ar.size() - 1);
            2'd2: begin
               best = 0;
               for (int i = 1; i < ar.size(); i++) if (ap[i] > ap[best]) best = i;
               sel.push_back(best);
            end
            default: for (int i = 0; i < ar.size(); i++) sel.push_back(i);
         endcase
      end
      en = (ar.size() == 0) ? 1 : sel.size();
      chk($sformatf("%s_nstrobe", nm), obs.size(), en);
      lim = (obs.size() < en) ? obs.size() : en;
      for (int k = 0; k < lim; k++) begin
         int er = (ar.size() == 0) ? 0 : ar[sel[k]];
         int ep = (ar.size() == 0) ? 0 : ap[sel[k]];
         int ei = (ar.size() == 0) ? 0 : sel[k];
         chk($sformatf("%s_cyc%0d", nm, k), obs[k].cyc, t_end + 2 + k);
         chk($sformatf("%s_rise%0d", nm, k), obs[k].rise, er);
         chk($sformatf("%s_pulse%0d", nm, k), obs[k].pulse, ep);
         chk($sformatf("%s_idx%0d", nm, k), obs[k].idx, ei);
         chk($sformatf("%s_cnt%0d", nm, k), obs[k].cnt, ar.size());
         chk($sformatf("%s_last%0d", nm, k), int'(obs[k].last), int'(k == en - 1));
         chk($sformatf("%s_ovf%0d", nm, k), int'(obs[k].ovf), int'(ov));
      end
   endtask

   typedef struct {
      logic [1:0] mode; int n; h8_t r; h8_t f; bit ewh;
      int en; int erise; int epulse; int eidx; int ecnt; bit eovf;
   } vec_t;
   vec_t tv[7];

   initial begin
      int t;
      h8_t rr, ff;
      tv[0] = '{2'd0, 3, h8(100, 300, 500), h8(140, 310, 600), 1'b0, 1, 100, 40, 0, 3, 1'b0};
      tv[1] = '{2'd2, 3, h8(100, 300, 500), h8(140, 400, 600), 1'b0, 1, 300, 100, 1, 3, 1'b0};
      tv[2] = '{2'd3, 6, h8(10, 30, 60, 100, 150, 210), h8(20, 50, 90, 140, 200, 270), 1'b0, 4, 10, 10, 0, 4, 1'b1};
      tv[3] = '{2'd1, 2, h8(200, 10), h8(150, 15), 1'b0, 1, 0, 0, 0, 0, 1'b0};
      tv[4] = '{2'd2, 4, h8(0, 20, 40, 300), h8(7, 28, 240, 501), 1'b0, 1, 40, 200, 1, 2, 1'b0};
      tv[5] = '{2'd1, 2, h8(5, 50), h8(5, 60), 1'b0, 1, 50, 10, 0, 1, 1'b0};
      tv[6] = '{2'd1, 2, h8(100, 200), h8(120, 260), 1'b1, 1, 200, 60, 1, 2, 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rise", int'(o_rise), 0);
      chk("rst_pulse", int'(o_pulse), 0);
      chk("rst_idx", int'(o_idx), 0);
      chk("rst_cnt", int'(o_cnt), 0);
      chk("rst_sig", int'(o_sig), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      for (int v = 0; v < 7; v++) begin
         run_shot(tv[v].mode, tv[v].n, tv[v].r, tv[v].f, tv[v].ewh, t);
         chk($sformatf("vec%0d_n", v), obs.size(), tv[v].en);
         if (obs.size() > 0) begin
            chk($sformatf("vec%0d_rise", v), obs[0].rise, tv[v].erise);
            chk($sformatf("vec%0d_pulse", v), obs[0].pulse, tv[v].epulse);
            chk($sformatf("vec%0d_idx", v), obs[0].idx, tv[v].eidx);
            chk($sformatf("vec%0d_cnt", v), obs[0].cnt, tv[v].ecnt);
            chk($sformatf("vec%0d_ovf", v), int'(obs[0].ovf), int'(tv[v].eovf));
            chk($sformatf("vec%0d_lastflag", v), int'(obs[obs.size()-1].last), 1);
         end
         model_check($sformatf("vec%0d", v), tv[v].mode, tv[v].n, tv[v].r, tv[v].f, t);
      end

      // Reset in the middle of a shot: nothing emitted, outputs cleared.
      obs.delete();
      start_shot(2'd0);
      hit(16'd100, 16'd140);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_rise", int'(o_rise), 0);
      chk("midrst_pulse", int'(o_pulse), 0);
      chk("midrst_idx", int'(o_idx), 0);
      chk("midrst_cnt", int'(o_cnt), 0);
      @(posedge clk); #1;
      end_shot(t);
      repeat (ME + 4) @(posedge clk);
      #1;
      chk("midrst_nstrobe", obs.size(), 0);

      // Restart of a shot while collecting.
      obs.delete();
      start_shot(2'd3);
      hit(16'd10, 16'd20);
      hit(16'd30, 16'd40);
      start_shot(2'd3);
      hit(16'd70, 16'd90);
      end_shot(t);
      repeat (ME + 4) @(posedge clk);
      #1;
      chk("restart_n", obs.size(), 1);
      if (obs.size() > 0) begin
         chk("restart_cnt", obs[0].cnt, 1);
         chk("restart_rise", obs[0].rise, 70);
         chk("restart_pulse", obs[0].pulse, 20);
         chk("restart_cyc", obs[0].cyc, t + 2);
         chk("restart_last", int'(obs[0].last), 1);
      end

      for (int s = 0; s < 40; s++) begin
         logic [1:0] m;
         int n;
         bit ewh;
         m = 2'($urandom_range(0, 3));
         n = $urandom_range(0, 6);
         rr = '0; ff = '0;
         for (int i = 0; i < 8; i++) begin
            int ri = $urandom_range(0, 1000);
            rr[i] = w_t'(ri);
            if ($urandom_range(0, 5) == 0) ff[i] = w_t'((ri > 0) ? ri - 1 : ri + 3);
            else ff[i] = w_t'(ri + $urandom_range(0, 230));
         end
         ewh = (n > 0) && ($urandom_range(0, 1) == 1);
         run_shot(m, n, rr, ff, ewh, t);
         model_check($sformatf("rnd%0d", s), m, n, rr, ff, t);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule

// File: doc/tdc_echo_pre.md
Name: tdc_echo_pre

Overview:
- Multi-echo successor to the single-hit TDC pre-processing stage.
- Per laser shot it collects up to MAX_ECHO rise/fall TDC hits and validates each one: fall >= rise, and pulse width inside [MIN_PW, MAX_PW].
- Selects echoes per a run-time mode (first, last, widest, all) and streams them to the distance-calculation stage as rise time plus pulse width with a valid strobe.
- Sits between the AS6500 TDC readout control and the distance calculation.

Parameters:
- DW, 16: width of TDC rise/fall words and pulse width.
- MAX_ECHO, 4: hit buffer depth per shot (2..16).
- IDX_W, 2: index width, clog2(MAX_ECHO).
- MIN_PW, 16'd0: minimum accepted pulse width, inclusive.
- MAX_PW, 16'hFFFF: maximum accepted pulse width, inclusive.

Ports:
- i_clk_50m  in  1  system clock.
- i_rst  in  1  synchronous active-high reset.
- i_shot_start  in  1  one-cycle strobe, new shot begins.
- i_shot_end  in  1  one-cycle strobe, shot window closed.
- i_mode  in  2  0=first, 1=last, 2=widest, 3=all; sampled at shot start.
- i_tdc_new_sig  in  1  level, high while a new hit's data is stable.
- i_rise_data  in  DW  rising-edge TDC time.
- i_fall_data  in  DW  falling-edge TDC time.
- o_rise_data  out  DW  emitted echo rise time.
- o_pulse_data  out  DW  emitted echo pulse width (fall - rise).
- o_echo_idx  out  IDX_W  hit order of emitted echo within shot, 0-based among accepted hits.
- o_echo_cnt  out  IDX_W+1  accepted hits this shot; valid with o_dist_cal_sig.
- o_dist_cal_sig  out  1  one-cycle valid per emitted echo.
- o_echo_last  out  1  marks final emitted echo of the shot.
- o_overflow  out  1  shot had more than MAX_ECHO valid hits, or hits arrived outside COLLECT; valid with o_dist_cal_sig.

Behaviour:
- Reset: all outputs 0, buffer count 0, state IDLE. Reset mid-shot discards all collected data with no emission.
- i_tdc_new_sig is registered once. A hit is detected on the cycle the registered copy is 1 and its previous value was 0, i.e. one cycle after the input rises. i_rise_data/i_fall_data are sampled on that detect cycle.
- Validation:
  - pw = fall - rise, DW bits, unsigned.
  - Hit accepted iff fall >= rise and MIN_PW <= pw <= MAX_PW.
  - Rejected hits are discarded silently and not counted.
- States:
  - IDLE: wait for i_shot_start; latch i_mode; clear count, overflow and running-best registers; go to COLLECT.
  - COLLECT:
    - Accepted hits are written to buffer[count] and count increments.
    - Accepted hit with count == MAX_ECHO: not stored, overflow set.
    - Running trackers are updated on each store: first = index 0; last = most recent; widest = strictly greater pw replaces, so ties keep the earliest.
    - i_shot_end goes to SELECT. A hit detected in the same cycle as i_shot_end is still accepted.
    - i_shot_start in COLLECT restarts the shot: clears state and re-latches mode.
  - SELECT (1 cycle): choose the emission range. Modes 0/1/2 emit one entry. Mode 3 emits entries 0..count-1. count == 0 emits one null echo.
  - EMIT: one echo per cycle with o_dist_cal_sig=1; o_echo_last=1 on the final one; then go to IDLE.
  - Null echo: rise=0, pulse=0, idx=0, cnt=0, last=1.
- Latency: i_shot_end at cycle T gives the first o_dist_cal_sig at T+2. Mode 3 with n echoes occupies T+2..T+n+1.
- Hits detected in SELECT, EMIT or IDLE are dropped. If during SELECT/EMIT, overflow is set in the outputs still to be emitted for the current shot.
- i_shot_start during SELECT/EMIT is ignored; upstream guarantees a gap of at least MAX_ECHO+2 cycles.
- o_rise_data, o_pulse_data, o_echo_idx and o_echo_cnt hold their last values between strobes. o_dist_cal_sig, o_echo_last and o_overflow are 0 when not emitting.

Test Plan:
- Mode 0: hits (100,140), (300,310), (500,600), then shot_end -> single strobe at T+2: rise=100, pulse=40, idx=0, cnt=3, last=1.
- Mode 2: hits (100,140), (300,400), (500,600) -> rise=300, pulse=100, idx=1 (tie with idx 2, earliest kept).
- Mode 3, MAX_ECHO=4: 6 valid hits -> 4 consecutive strobes, idx 0..3, cnt=4, overflow=1 on each, last only on 4th.
- Hit (200,150) and, with MIN_PW=8, hit (10,15) -> both rejected; shot_end -> null echo: rise=0, pulse=0, cnt=0, last=1.
- Mode 1: hit detected in the same cycle as shot_end -> that hit is emitted as last. Separately, i_rst asserted mid-COLLECT -> no strobe, all outputs 0 next cycle.
- Mode 3: i_shot_start re-issued mid-COLLECT after 2 hits, then 1 hit and shot_end -> one strobe only, cnt=1.
